y_update_engine: RTL and testbench

//  Parametrised complex accumulate engine for change-in-Y matrix updates.

---
 rtl/y_update_engine.sv | 143 ++++++++++++++
 tb/tb_y_update_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/y_update_engine.sv
// Complex accumulate engine: loads a {real,imag} base Y entry and applies up to MAX_TERMS streamed deltas.
// Optional feature macro SATURATE_EN: per-component clamping with sticky ovf; otherwise modulo wrap, ovf=0.
module y_update_engine #(
  parameter int HALF_W    = 24,
  parameter int MAX_TERMS = 4,
  parameter int CNT_W     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                execute_en,
  input  logic                start,
  input  logic [2*HALF_W-1:0] y_base,
  input  logic [CNT_W-1:0]    n_terms,
  input  logic                delta_valid,
  output logic                delta_ready,
  input  logic [2*HALF_W-1:0] delta_val,
  input  logic                delta_sub,
  output logic [2*HALF_W-1:0] y_out,
  output logic                done,
  output logic                busy,
  output logic                ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

`ifdef SATURATE_EN
  localparam logic [HALF_W-1:0] POS_LIM = {1'b0, {(HALF_W-1){1'b1}}};
  localparam logic [HALF_W-1:0] NEG_LIM = {1'b1, {(HALF_W-1){1'b0}}};

  // One guard bit is enough: sum/difference of two HALF_W-bit values fits in HALF_W+1.
  function automatic logic [HALF_W:0] widen(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b,
                                            input logic sub);
    return sub ? {a[HALF_W-1], a} - {b[HALF_W-1], b} : {a[HALF_W-1], a} + {b[HALF_W-1], b};
  endfunction

  function automatic logic step_ovf(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b,
                                    input logic sub);
    logic [HALF_W:0] wide;
    wide = widen(a, b, sub);
    return wide[HALF_W] ^ wide[HALF_W-1];
  endfunction

  function automatic logic [HALF_W-1:0] step(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b,
                                             input logic sub);
    logic [HALF_W:0] wide;
    wide = widen(a, b, sub);
    if (wide[HALF_W] ^ wide[HALF_W-1]) return wide[HALF_W] ? NEG_LIM : POS_LIM;
    return wide[HALF_W-1:0];
  endfunction
`else
  function automatic logic [HALF_W-1:0] step(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b,
                                             input logic sub);
    return sub ? a - b : a + b;
  endfunction
`endif

  state_t             state_reg;
  logic [HALF_W-1:0]  acc_re_reg, acc_im_reg;
  logic [CNT_W-1:0]   count_reg, n_lat_reg;
  logic [HALF_W-1:0]  next_re, next_im;
  logic [CNT_W-1:0]   count_inc, n_clamped;
  logic               handshake;

  assign next_re     = step(acc_re_reg, delta_val[2*HALF_W-1:HALF_W], delta_sub);
  assign next_im     = step(acc_im_reg, delta_val[HALF_W-1:0], delta_sub);
  assign count_inc   = count_reg + 1'b1;
  assign n_clamped   = (n_terms > MAX_CNT) ? MAX_CNT : n_terms;
  assign delta_ready = (state_reg == ACC) && execute_en;
  assign handshake   = delta_valid && delta_ready;

`ifdef SATURATE_EN
  logic ovf_reg;
  logic ovf_step;
  assign ovf_step = step_ovf(acc_re_reg, delta_val[2*HALF_W-1:HALF_W], delta_sub)
                  | step_ovf(acc_im_reg, delta_val[HALF_W-1:0], delta_sub);
  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= IDLE;
      acc_re_reg <= '0;
      acc_im_reg <= '0;
      count_reg  <= '0;
      n_lat_reg  <= '0;
      y_out      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef SATURATE_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && execute_en) begin
            acc_re_reg <= y_base[2*HALF_W-1:HALF_W];
            acc_im_reg <= y_base[HALF_W-1:0];
            count_reg  <= '0;
            n_lat_reg  <= n_clamped;
            busy       <= 1'b1;
`ifdef SATURATE_EN
            ovf_reg    <= 1'b0;
`endif
            // A zero-term update completes straight away with the base value as result.
            if (n_clamped == '0) begin
              y_out     <= y_base;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        ACC: begin
          if (handshake) begin
            acc_re_reg <= next_re;
            acc_im_reg <= next_im;
            count_reg  <= count_inc;
`ifdef SATURATE_EN
            ovf_reg    <= ovf_reg | ovf_step;
`endif
            if (count_inc == n_lat_reg) begin
              y_out     <= {next_re, next_im};
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_update_engine.sv
// Self-checking bench for y_update_engine: directed table, stall/reset sequences, randomized updates vs model.
module tb_y_update_engine;
  logic        clock = 1'b0;
  logic        reset;
  logic        execute_en, start, delta_valid, delta_ready, delta_sub, done, busy, ovf;
  logic [47:0] y_base, delta_val, y_out;
  logic [2:0]  n_terms;

  int vectors = 0;
  int miscompares = 0;

  y_update_engine #(.HALF_W(24), .MAX_TERMS(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .execute_en(execute_en), .start(start),
    .y_base(y_base), .n_terms(n_terms), .delta_valid(delta_valid), .delta_ready(delta_ready),
    .delta_val(delta_val), .delta_sub(delta_sub), .y_out(y_out), .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0]       base;
    logic [2:0]        n;
    logic [3:0][47:0]  dv;
    logic [3:0]        ds;
    logic [47:0]       exp_y;
    logic              exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic per component, clamp or wrap after each term.
  function automatic longint fix(input longint v);
    logic [23:0] t;
`ifdef SATURATE_EN
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
`else
    t = v[23:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic logic [48:0] model(input logic [47:0] base, input logic [2:0] n,
                                        input logic [3:0][47:0] dv, input logic [3:0] ds);
    longint re, im, d_re, d_im;
    bit o;
    int neff;
    logic [23:0] t;
    o = 0;
    neff = (n > 3'd4) ? 4 : int'(n);
    t = base[47:24]; re = longint'($signed(t));
    t = base[23:0];  im = longint'($signed(t));
    for (int i = 0; i < neff; i++) begin
      t = dv[i][47:24]; d_re = longint'($signed(t));
      t = dv[i][23:0];  d_im = longint'($signed(t));
      re = ds[i] ? re - d_re : re + d_re;
      im = ds[i] ? im - d_im : im + d_im;
`ifdef SATURATE_EN
      if (fix(re) != re || fix(im) != im) o = 1;
`endif
      re = fix(re);
      im = fix(im);
    end
    return {o, re[23:0], im[23:0]};
  endfunction

  task automatic do_update(input logic [47:0] base, input logic [2:0] n, input logic [3:0][47:0] dv,
                           input logic [3:0] ds, input bit rnd, input int stall,
                           input logic [47:0] exp_y, input logic exp_o, input string tag);
    int neff, k, cyc;
    bit ready_bad, early_done, hs, en;
    logic [63:0] junk;
    logic [47:0] y_keep;
    neff = (n > 3'd4) ? 4 : int'(n);
    @(negedge clock);
    start = 1; y_base = base; n_terms = n; execute_en = 1; delta_valid = 0;
    @(negedge clock);
    k = 0; cyc = 0; ready_bad = 0; early_done = 0;
    while (k < neff && cyc < 300) begin
      if (done) early_done = 1;
      en = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      execute_en  = en;
      delta_valid = (cyc < stall) ? 1'b1 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      junk = {$urandom, $urandom};
      delta_val = delta_valid ? dv[k] : junk[47:0];
      delta_sub = delta_valid ? ds[k] : junk[48];
      start   = rnd ? junk[49] : 1'b0;
      y_base  = junk[63:16];
      n_terms = junk[2:0];
      #1;
      if (delta_ready !== en) ready_bad = 1;
      hs = delta_valid && delta_ready;
      @(negedge clock);
      if (hs) k++;
      cyc++;
    end
    start = 0; delta_valid = 0;
    execute_en = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
    #1;
    chk({tag, " handshakes"}, 64'(k), 64'(neff));
    chk({tag, " ready_tracks_en"}, 64'(ready_bad), 64'd0);
    chk({tag, " no_early_done"}, 64'(early_done), 64'd0);
    chk({tag, " done_latency"}, 64'(done), 64'd1);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd1);
    chk({tag, " ready_low_in_done"}, 64'(delta_ready), 64'd0);
    chk({tag, " y_out"}, 64'(y_out), 64'(exp_y));
    chk({tag, " ovf"}, 64'(ovf), 64'(exp_o));
    y_keep = y_out;
    @(negedge clock);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " busy_cleared"}, 64'(busy), 64'd0);
    chk({tag, " y_out_hold"}, 64'(y_out), 64'(y_keep));
    execute_en = 1;
    $display("update %s: n=%0d y_out=%h ovf=%b expected %h/%b", tag, n, y_keep, ovf, exp_y, exp_o);
  endtask

  vec_t vecs[7];
  logic [3:0][47:0] rdv;
  logic [3:0] rds;
  logic [47:0] rbase;
  logic [2:0] rn;
  logic [48:0] m;

  initial begin
    // 1: basic add/sub; 2: zero terms; 3/4: pos/neg overflow; 5: n clamped to 4;
    // 6: both components overflow opposite ways; 7: no carry from imag into real.
    vecs[0] = '{48'h000064_FFFFCE, 3'd2, {48'd0, 48'd0, {24'd30, 24'hFFFFEC}, {24'd10, 24'd5}},
                4'b0010, {24'd80, 24'hFFFFE7}, 1'b0};
    vecs[1] = '{{24'd7, 24'hFFFFF9}, 3'd0, '0, 4'b0000, {24'd7, 24'hFFFFF9}, 1'b0};
    vecs[4] = '{48'h0, 3'd7, {4{24'd1, 24'd2}}, 4'b0000, {24'd4, 24'd8}, 1'b0};
    vecs[6] = '{{24'd0, 24'hFFFFFF}, 3'd1, {144'd0, {24'd0, 24'd1}}, 4'b0000, 48'd0, 1'b0};
`ifdef SATURATE_EN
    vecs[2] = '{{24'h7FFFFF, 24'd0}, 3'd1, {144'd0, {24'd1, 24'd0}}, 4'b0000, {24'h7FFFFF, 24'd0}, 1'b1};
    vecs[3] = '{{24'h800000, 24'd0}, 3'd1, {144'd0, {24'd1, 24'd0}}, 4'b0001, {24'h800000, 24'd0}, 1'b1};
    vecs[5] = '{{24'h800000, 24'h7FFFFF}, 3'd2, {96'd0, {24'd0, 24'd1}, {24'd1, 24'd0}}, 4'b0001,
                {24'h800000, 24'h7FFFFF}, 1'b1};
`else
    vecs[2] = '{{24'h7FFFFF, 24'd0}, 3'd1, {144'd0, {24'd1, 24'd0}}, 4'b0000, {24'h800000, 24'd0}, 1'b0};
    vecs[3] = '{{24'h800000, 24'd0}, 3'd1, {144'd0, {24'd1, 24'd0}}, 4'b0001, {24'h7FFFFF, 24'd0}, 1'b0};
    vecs[5] = '{{24'h800000, 24'h7FFFFF}, 3'd2, {96'd0, {24'd0, 24'd1}, {24'd1, 24'd0}}, 4'b0001,
                {24'h7FFFFF, 24'h800000}, 1'b0};
`endif

    reset = 0; execute_en = 0; start = 0; y_base = '0; n_terms = '0;
    delta_valid = 0; delta_val = '0; delta_sub = 0;
    repeat (3) @(negedge clock);
    chk("reset y_out", 64'(y_out), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ready", 64'(delta_ready), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    reset = 1;

    for (int i = 0; i < 7; i++)
      do_update(vecs[i].base, vecs[i].n, vecs[i].dv, vecs[i].ds, 1'b0, 0,
                vecs[i].exp_y, vecs[i].exp_o, $sformatf("vec%0d", i));

    // execute_en low for 3 cycles in ACC with valid held high
    do_update(vecs[0].base, vecs[0].n, vecs[0].dv, vecs[0].ds, 1'b0, 3,
              vecs[0].exp_y, vecs[0].exp_o, "stall3");

    // reset after the first of two deltas
    @(negedge clock);
    start = 1; y_base = vecs[0].base; n_terms = 3'd2; execute_en = 1;
    @(negedge clock);
    start = 0; delta_valid = 1; delta_val = vecs[0].dv[0]; delta_sub = 1'b0;
    @(negedge clock);
    delta_valid = 0; reset = 0;
    @(negedge clock);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset y_out", 64'(y_out), 64'd0);
    chk("midreset ready", 64'(delta_ready), 64'd0);
    reset = 1;
    do_update(vecs[0].base, vecs[0].n, vecs[0].dv, vecs[0].ds, 1'b0, 0,
              vecs[0].exp_y, vecs[0].exp_o, "after_reset");

    for (int r = 0; r < 40; r++) begin
      rbase = {$urandom, $urandom_range(0, 65535)};
      rn = 3'($urandom_range(0, 7));
      for (int j = 0; j < 4; j++) rdv[j] = {$urandom, $urandom_range(0, 65535)};
      rds = 4'($urandom_range(0, 15));
      m = model(rbase, rn, rdv, rds);
      do_update(rbase, rn, rdv, rds, 1'b1, 0, m[47:0], m[48], $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
